// File: rtl/axistream_pkg.sv
// Shared definitions for the AXI4-Stream blocks: default widths and the tkeep width helper.
package axistream_pkg;

    localparam int AXIS_DATA_W_DEF = 32;
    localparam int AXIS_USER_W_DEF = 1;

    function automatic int keep_w(int data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/axistream_fifo_mem.sv
// Simple dual-port storage for the stream FIFO: registered write port, asynchronous read port.
module axistream_fifo_mem #(
    parameter int WIDTH = 38,
    parameter int DEPTH = 16,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WIDTH-1:0]  rd_data
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // NOTE: the array has no reset; contents are only observed behind the pointer
    // logic, and leaving it unreset lets it map onto RAM primitives.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/axistream_fifo.sv
// Synchronous first-word-fall-through AXI4-Stream FIFO.
// Define AXISTREAM_FIFO_PACKET_EN for store-and-forward (packet) mode.
module axistream_fifo
    import axistream_pkg::*;
#(
    parameter int DATA_W = AXIS_DATA_W_DEF,
    parameter int USER_W = AXIS_USER_W_DEF,
    parameter int DEPTH  = 16,
    localparam int KEEP_W = keep_w(DATA_W),
    localparam int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic              aclk,
    input  logic              aresetn,

    input  logic              s_axis_tvalid,
    output logic              s_axis_tready,
    input  logic [DATA_W-1:0] s_axis_tdata,
    input  logic [KEEP_W-1:0] s_axis_tkeep,
    input  logic              s_axis_tlast,
    input  logic [USER_W-1:0] s_axis_tuser,

    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic [DATA_W-1:0] m_axis_tdata,
    output logic [KEEP_W-1:0] m_axis_tkeep,
    output logic              m_axis_tlast,
    output logic [USER_W-1:0] m_axis_tuser,

    output logic [CNT_W-1:0]  count
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam int PTR_W  = ADDR_W + 1;
    localparam int BEAT_W = DATA_W + KEEP_W + 1 + USER_W;

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              s_ready_q, s_ready_d;

    logic              full, empty, full_d;
    logic              wr_en, rd_en;
    logic [BEAT_W-1:0] wr_beat, rd_beat;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign full  = (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]) &&
                   (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]);
    assign empty = (wr_ptr_q == rd_ptr_q);

    assign wr_en = s_axis_tvalid && s_ready_q;
    assign rd_en = m_axis_tvalid && m_axis_tready;

    // NOTE: every signal assigned in always_comb gets a default first so that no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (rd_en) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({wr_en, rd_en})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        full_d    = (wr_ptr_d[ADDR_W] != rd_ptr_d[ADDR_W]) &&
                    (wr_ptr_d[ADDR_W-1:0] == rd_ptr_d[ADDR_W-1:0]);
        s_ready_d = !full_d;
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the pre-edge value of its inputs regardless of statement order.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            s_ready_q <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            s_ready_q <= s_ready_d;
        end
    end

`ifdef AXISTREAM_FIFO_PACKET_EN
    logic [PTR_W-1:0] pkt_cnt_q, pkt_cnt_d;
    logic             wr_last, rd_last;

    always_comb begin
        wr_last   = wr_en && s_axis_tlast;
        rd_last   = rd_en && m_axis_tlast;
        pkt_cnt_d = pkt_cnt_q;
        if (wr_last && !rd_last) begin
            pkt_cnt_d = pkt_cnt_q + PTR_W'(1);
        end else if (!wr_last && rd_last) begin
            pkt_cnt_d = pkt_cnt_q - PTR_W'(1);
        end
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            pkt_cnt_q <= '0;
        end else begin
            pkt_cnt_q <= pkt_cnt_d;
        end
    end

    // A packet longer than the FIFO is released in cut-through once full.
    assign m_axis_tvalid = !empty && ((pkt_cnt_q != '0) || full);
`else
    assign m_axis_tvalid = !empty;
`endif

    assign wr_beat = {s_axis_tuser, s_axis_tlast, s_axis_tkeep, s_axis_tdata};

    axistream_fifo_mem #(
        .WIDTH (BEAT_W),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk     (aclk),
        .wr_en   (wr_en),
        .wr_addr (wr_ptr_q[ADDR_W-1:0]),
        .wr_data (wr_beat),
        .rd_addr (rd_ptr_q[ADDR_W-1:0]),
        .rd_data (rd_beat)
    );

    assign {m_axis_tuser, m_axis_tlast, m_axis_tkeep, m_axis_tdata} = rd_beat;

    assign s_axis_tready = s_ready_q;
    assign count         = count_q;

endmodule

// File: tb/tb_axistream_fifo.sv
// Self-checking bench for axistream_fifo: directed vector table, fill/drain, concurrent,
// randomized backpressure against a queue model, and packet mode when AXISTREAM_FIFO_PACKET_EN is set.
module tb_axistream_fifo;

    localparam int DATA_W = 32;
    localparam int KEEP_W = 4;
    localparam int USER_W = 1;
    localparam int DEPTH  = 16;
    localparam int CNT_W  = 5;

    logic              aclk = 1'b0;
    logic              aresetn = 1'b0;
    logic              s_axis_tvalid = 1'b0;
    logic              s_axis_tready;
    logic [DATA_W-1:0] s_axis_tdata = '0;
    logic [KEEP_W-1:0] s_axis_tkeep = '0;
    logic              s_axis_tlast = 1'b0;
    logic [USER_W-1:0] s_axis_tuser = '0;
    logic              m_axis_tvalid;
    logic              m_axis_tready = 1'b0;
    logic [DATA_W-1:0] m_axis_tdata;
    logic [KEEP_W-1:0] m_axis_tkeep;
    logic              m_axis_tlast;
    logic [USER_W-1:0] m_axis_tuser;
    logic [CNT_W-1:0]  count;

    axistream_fifo #(
        .DATA_W (DATA_W),
        .USER_W (USER_W),
        .DEPTH  (DEPTH)
    ) dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tkeep  (s_axis_tkeep),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tuser  (s_axis_tuser),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tuser  (m_axis_tuser),
        .count         (count)
    );

    always #5 aclk = ~aclk;

    typedef struct {
        logic [DATA_W-1:0] data;
        logic [KEEP_W-1:0] keep;
        logic              last;
        logic [USER_W-1:0] user;
    } beat_t;

    typedef struct {
        bit                sv;
        logic [DATA_W-1:0] d;
        bit                mr;
        int                exp_cnt;
        bit                exp_sr;
        bit                exp_mv;
        logic [DATA_W-1:0] exp_d;
    } vec_t;

    beat_t model_q[$];
    bit    exp_ready = 1'b0;
    int    checks    = 0;
    int    errors    = 0;
    int    delivered = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Downstream valid as the rules define it: any beats stored, and in packet mode
    // a complete packet stored or the FIFO full.
    function automatic bit model_valid();
`ifdef AXISTREAM_FIFO_PACKET_EN
        int lasts = 0;
        foreach (model_q[i]) if (model_q[i].last) lasts++;
        return (model_q.size() > 0) && ((lasts > 0) || (model_q.size() == DEPTH));
`else
        return model_q.size() > 0;
`endif
    endfunction

    task automatic drive(input bit v, input logic [DATA_W-1:0] d, input logic [KEEP_W-1:0] k,
                         input bit l, input logic [USER_W-1:0] u, input bit mr);
        s_axis_tvalid = v;
        s_axis_tdata  = d;
        s_axis_tkeep  = k;
        s_axis_tlast  = l;
        s_axis_tuser  = u;
        m_axis_tready = mr;
    endtask

    task automatic step();
        bit    wr, rd;
        beat_t b;
        wr = s_axis_tvalid && exp_ready;
        rd = model_valid() && m_axis_tready;
        b  = '{s_axis_tdata, s_axis_tkeep, s_axis_tlast, s_axis_tuser};
        @(posedge aclk);
        if (rd) begin
            void'(model_q.pop_front());
            delivered++;
        end
        if (wr) model_q.push_back(b);
        exp_ready = (model_q.size() < DEPTH);
        #1;
        check("count", 64'(count), 64'(model_q.size()));
        check("s_tready", 64'(s_axis_tready), 64'(exp_ready));
        check("m_tvalid", 64'(m_axis_tvalid), 64'(model_valid()));
        if (model_valid()) begin
            check("m_tdata", 64'(m_axis_tdata), 64'(model_q[0].data));
            check("m_tkeep", 64'(m_axis_tkeep), 64'(model_q[0].keep));
            check("m_tlast", 64'(m_axis_tlast), 64'(model_q[0].last));
            check("m_tuser", 64'(m_axis_tuser), 64'(model_q[0].user));
        end
    endtask

    task automatic do_reset();
        aresetn = 1'b0;
        drive(1'b0, '0, '0, 1'b0, '0, 1'b0);
        repeat (3) @(posedge aclk);
        #1;
        model_q.delete();
        exp_ready = 1'b0;
        check("rst_m_tvalid", 64'(m_axis_tvalid), 64'd0);
        check("rst_s_tready", 64'(s_axis_tready), 64'd0);
        check("rst_count", 64'(count), 64'd0);
        aresetn = 1'b1;
        check("rst_release_s_tready_low", 64'(s_axis_tready), 64'd0);
        step();
        check("rst_s_tready_rise", 64'(s_axis_tready), 64'd1);
    endtask

    vec_t vecs[9];

    initial begin
        int base;
        int wr_k;

        vecs[0] = '{1'b1, 32'hA0, 1'b0, 1, 1'b1, 1'b1, 32'hA0};
        vecs[1] = '{1'b1, 32'hA1, 1'b0, 2, 1'b1, 1'b1, 32'hA0};
        vecs[2] = '{1'b1, 32'hA2, 1'b1, 2, 1'b1, 1'b1, 32'hA1};
        vecs[3] = '{1'b0, 32'h00, 1'b1, 1, 1'b1, 1'b1, 32'hA2};
        vecs[4] = '{1'b1, 32'hA3, 1'b1, 1, 1'b1, 1'b1, 32'hA3};
        vecs[5] = '{1'b0, 32'h00, 1'b1, 0, 1'b1, 1'b0, 32'h00};
        vecs[6] = '{1'b0, 32'h00, 1'b1, 0, 1'b1, 1'b0, 32'h00};
        vecs[7] = '{1'b1, 32'hA4, 1'b1, 1, 1'b1, 1'b1, 32'hA4};
        vecs[8] = '{1'b0, 32'h00, 1'b1, 0, 1'b1, 1'b0, 32'h00};

        // Reset behaviour
        do_reset();

        // Directed vector table
        for (int i = 0; i < 9; i++) begin
            drive(vecs[i].sv, vecs[i].d, 4'hF, 1'b1, 1'b0, vecs[i].mr);
            step();
            check($sformatf("vec%0d_count", i), 64'(count), 64'(vecs[i].exp_cnt));
            check($sformatf("vec%0d_s_tready", i), 64'(s_axis_tready), 64'(vecs[i].exp_sr));
            check($sformatf("vec%0d_m_tvalid", i), 64'(m_axis_tvalid), 64'(vecs[i].exp_mv));
            if (vecs[i].exp_mv) begin
                check($sformatf("vec%0d_m_tdata", i), 64'(m_axis_tdata), 64'(vecs[i].exp_d));
            end
        end

        // Fill to DEPTH, then offer a 17th beat that must not be stored
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b1, 32'(i), 4'(i), (i == DEPTH - 1), 1'(i), 1'b0);
            step();
        end
        check("fill_count", 64'(count), 64'(DEPTH));
        check("fill_s_tready", 64'(s_axis_tready), 64'd0);
        drive(1'b1, 32'd99, 4'hF, 1'b1, 1'b1, 1'b0);
        step();
        step();
        check("fill_17th_held", 64'(count), 64'(DEPTH));

        // Drain in order
        drive(1'b0, '0, '0, 1'b0, '0, 1'b1);
        for (int i = 0; i < DEPTH; i++) begin
            check($sformatf("drain%0d_data", i), 64'(m_axis_tdata), 64'(i));
            check($sformatf("drain%0d_keep", i), 64'(m_axis_tkeep), 64'(i % 16));
            check($sformatf("drain%0d_last", i), 64'(m_axis_tlast), 64'(i == DEPTH - 1));
            step();
        end
        check("drain_count", 64'(count), 64'd0);
        check("drain_m_tvalid", 64'(m_axis_tvalid), 64'd0);

        // Concurrent read+write at count=4
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'(1000 + i), 4'hF, 1'b1, 1'b0, 1'b0);
            step();
        end
        base = delivered;
        for (int i = 0; i < 100; i++) begin
            drive(1'b1, 32'(2000 + i), 4'(i), 1'b1, 1'(i), 1'b1);
            step();
            check("concurrent_count", 64'(count), 64'd4);
        end
        check("concurrent_delivered", 64'(delivered - base), 64'd100);
        drive(1'b0, '0, '0, 1'b0, '0, 1'b1);
        for (int i = 0; i < 8 && model_q.size() > 0; i++) step();
        check("concurrent_empty", 64'(count), 64'd0);

        // Randomized traffic with backpressure
        for (int i = 0; i < 3000; i++) begin
            drive(1'($urandom % 2), $urandom, 4'($urandom), ($urandom % 4) == 0,
                  1'($urandom), 1'($urandom % 2));
            step();
        end
        drive(1'b0, '0, '0, 1'b0, '0, 1'b1);
        for (int i = 0; i < 2 * DEPTH && model_valid(); i++) step();

`ifdef AXISTREAM_FIFO_PACKET_EN
        // Store-and-forward: nothing visible until tlast is stored
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'(300 + i), 4'hF, 1'b0, 1'b0, 1'b1);
            step();
            check("pkt_hold_m_tvalid", 64'(m_axis_tvalid), 64'd0);
        end
        drive(1'b1, 32'd303, 4'hF, 1'b1, 1'b0, 1'b1);
        step();
        check("pkt_release_m_tvalid", 64'(m_axis_tvalid), 64'd1);
        drive(1'b0, '0, '0, 1'b0, '0, 1'b1);
        for (int i = 0; i < 4; i++) step();
        check("pkt_drained", 64'(count), 64'd0);

        // 20-beat packet into a 16-deep FIFO must cut through once full
        base = delivered;
        wr_k = 0;
        for (int cyc = 0; cyc < 600 && (delivered - base) < 20; cyc++) begin
            if (wr_k < 20) drive(1'b1, 32'(500 + wr_k), 4'hF, (wr_k == 19), 1'b0, 1'b1);
            else           drive(1'b0, '0, '0, 1'b0, '0, 1'b1);
            if (wr_k < 20 && exp_ready) wr_k++;
            step();
        end
        check("pkt_long_delivered", 64'(delivered - base), 64'd20);
        check("pkt_long_empty", 64'(count), 64'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
